id_ex_pipe_reg: RTL and testbench

//  ID/EX pipeline register for the 5-stage MIPS core, directly downstream of the decode control unit.

---
 rtl/mips_pipe_pkg.sv | 19 +
 rtl/id_ex_pipe_reg_if.sv | 23 ++
 rtl/load_use_hazard.sv | 79 +++++++
 rtl/id_ex_pipe_reg.sv | 136 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline: control-word layout and hazard FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pipe_pkg;

  // Control word layout {WB[8:7], M[6:4], EX[3:0]}
  localparam int CTRL_W        = 9;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_REGWRITE = 7;
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 9'h000;

  typedef enum logic [0:0] {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Stage bus carrying one decoded instruction (ID outputs or EX register contents).
// Latency: n/a (wires only).
// Backpressure: none; the consumer always accepts.
// Signals: valid, ctrl[8:0], pc4, rs_data, rt_data, imm (DATA_W), rs/rt/rd (5).
// Modports: master drives the bundle, slave receives it.
interface id_ex_pipe_reg_if
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;

  modport master (output valid, ctrl, pc4, rs_data, rt_data, imm, rs, rt, rd);
  modport slave  (input  valid, ctrl, pc4, rs_data, rt_data, imm, rs, rt, rd);
endinterface

// File: rtl/load_use_hazard.sv
// Load-use hazard detector and stall sequencer: decides when ID/EX takes a bubble and PC/IF-ID hold.
// Latency: outputs are combinational from current FSM state, EX contents and ID specifiers.
// Backpressure: drives pc_write/ifid_write low to hold upstream; flush overrides any stall.
// Ports: clk, rst_n (sync, active-low); id_valid, id_rs, id_rt; ex_valid, ex_memread, ex_rt; flush;
//        outputs bubble, pc_write, ifid_write.
module load_use_hazard
  import mips_pipe_pkg::*;
#(
  parameter int STALL_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       flush,
  output logic       bubble,
  output logic       pc_write,
  output logic       ifid_write
);

  localparam int CNT_W = 3;
  localparam logic [0:0] ST_RUN   = HZ_RUN;
  localparam logic [0:0] ST_STALL = HZ_STALL;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             hold;

  // Writes to $0 never create a dependency.
  assign hazard = id_valid & ex_valid & ex_memread & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bubble  = 1'b0;
    hold    = 1'b0;
    if (flush) begin
      // The held IF/ID instruction is squashed upstream, so any pending stall is moot.
      bubble  = 1'b1;
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (state_q == ST_STALL) begin
      // No hazard re-check here: the first bubble already cleared EX memread.
      bubble = 1'b1;
      hold   = 1'b1;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_RUN;
      end
    end else if (hazard) begin
      bubble = 1'b1;
      hold   = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_d = ST_STALL;
        cnt_d   = CNT_W'(STALL_CYCLES - 1);
      end
    end
  end

  assign pc_write   = ~hold;
  assign ifid_write = ~hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and optional hazard counters.
// Latency: 1 cycle ID->EX; pc_write/ifid_write are combinational.
// Backpressure: none from downstream; stalls upstream via pc_write/ifid_write on load-use.
// Ports: clk, rst_n (sync, active-low); id_bus (slave), ex_bus (master); flush;
//        pc_write, ifid_write, stall_cnt, flush_cnt.
// Build option: define HAZARD_PERF_EN to enable stall_cnt/flush_cnt; otherwise both read 0.
module id_ex_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int STALL_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  id_ex_pipe_reg_if.slave    id_bus,
  id_ex_pipe_reg_if.master   ex_bus,
  input  logic               flush,
  output logic               pc_write,
  output logic               ifid_write,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
);

  logic              ex_valid_q,   ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
  logic [DATA_W-1:0] ex_pc4_q,     ex_pc4_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [4:0]        ex_rs_q,      ex_rs_d;
  logic [4:0]        ex_rt_q,      ex_rt_d;
  logic [4:0]        ex_rd_q,      ex_rd_d;
  logic              bubble;

  load_use_hazard #(
    .STALL_CYCLES (STALL_CYCLES)
  ) u_hazard (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_bus.valid),
    .id_rs      (id_bus.rs),
    .id_rt      (id_bus.rt),
    .ex_valid   (ex_valid_q),
    .ex_memread (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rt      (ex_rt_q),
    .flush      (flush),
    .bubble     (bubble),
    .pc_write   (pc_write),
    .ifid_write (ifid_write)
  );

  always_comb begin
    ex_pc4_d     = ex_pc4_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    ex_valid_d   = 1'b0;
    ex_ctrl_d    = CTRL_BUBBLE;
    if (!bubble) begin
      ex_valid_d   = id_bus.valid;
      // An invalid ID slot must not leak side effects, whatever decode produced.
      ex_ctrl_d    = id_bus.valid ? id_bus.ctrl : CTRL_BUBBLE;
      ex_pc4_d     = id_bus.pc4;
      ex_rs_data_d = id_bus.rs_data;
      ex_rt_data_d = id_bus.rt_data;
      ex_imm_d     = id_bus.imm;
      ex_rs_d      = id_bus.rs;
      ex_rt_d      = id_bus.rt;
      ex_rd_d      = id_bus.rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= CTRL_BUBBLE;
      ex_pc4_q     <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_pc4_q     <= ex_pc4_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
    end
  end

  assign ex_bus.valid   = ex_valid_q;
  assign ex_bus.ctrl    = ex_ctrl_q;
  assign ex_bus.pc4     = ex_pc4_q;
  assign ex_bus.rs_data = ex_rs_data_q;
  assign ex_bus.rt_data = ex_rt_data_q;
  assign ex_bus.imm     = ex_imm_q;
  assign ex_bus.rs      = ex_rs_q;
  assign ex_bus.rt      = ex_rt_q;
  assign ex_bus.rd      = ex_rd_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, ~pc_write};
    flush_cnt_d = flush_cnt_q + {31'd0, flush & id_bus.valid};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: two instances (STALL_CYCLES 1 and 3) share one ID stimulus stream.
// Latency: a reference model predicts the EX registers one cycle after each ID input.
// Backpressure: the stimulus keeps the ID instruction steady while a stall is expected.
module tb_id_ex_pipe_reg;

  logic clk;
  logic rst_n;
  logic flush;
  logic pcw1, ifw1, pcw3, ifw3;
  logic [31:0] sc1, fc1, sc3, fc3;

  id_ex_pipe_reg_if #(.DATA_W(32)) id_if ();
  id_ex_pipe_reg_if #(.DATA_W(32)) ex1 ();
  id_ex_pipe_reg_if #(.DATA_W(32)) ex3 ();

  id_ex_pipe_reg #(.DATA_W(32), .STALL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_bus(id_if), .ex_bus(ex1), .flush(flush),
    .pc_write(pcw1), .ifid_write(ifw1), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  id_ex_pipe_reg #(.DATA_W(32), .STALL_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_bus(id_if), .ex_bus(ex3), .flush(flush),
    .pc_write(pcw3), .ifid_write(ifw3), .stall_cnt(sc3), .flush_cnt(fc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs of both instances, index 0 = STALL_CYCLES 1, index 1 = STALL_CYCLES 3.
  logic [1:0]       o_valid, o_pcw, o_ifw;
  logic [1:0][8:0]  o_ctrl;
  logic [1:0][31:0] o_pc4, o_rsd, o_rtd, o_imm, o_sc, o_fc;
  logic [1:0][4:0]  o_rs, o_rt, o_rd;
  assign o_valid = {ex3.valid, ex1.valid};
  assign o_pcw   = {pcw3, pcw1};
  assign o_ifw   = {ifw3, ifw1};
  assign o_ctrl  = {ex3.ctrl, ex1.ctrl};
  assign o_pc4   = {ex3.pc4, ex1.pc4};
  assign o_rsd   = {ex3.rs_data, ex1.rs_data};
  assign o_rtd   = {ex3.rt_data, ex1.rt_data};
  assign o_imm   = {ex3.imm, ex1.imm};
  assign o_sc    = {sc3, sc1};
  assign o_fc    = {fc3, fc1};
  assign o_rs    = {ex3.rs, ex1.rs};
  assign o_rt    = {ex3.rt, ex1.rt};
  assign o_rd    = {ex3.rd, ex1.rd};

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what each EX register must hold, plus remaining hold cycles.
  int          stall_len [2] = '{1, 3};
  logic        m_known = 1'b0;
  logic        m_valid [2];
  logic [8:0]  m_ctrl  [2];
  logic [31:0] m_pc4 [2], m_rsd [2], m_rtd [2], m_imm [2];
  logic [4:0]  m_rs [2], m_rt [2], m_rd [2];
  int          m_hold  [2] = '{0, 0};
  logic [31:0] m_sc [2], m_fc [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic hz;
      logic stalling;
      logic [31:0] exp_sc, exp_fc;
      hz = id_if.valid && m_valid[k] && m_ctrl[k][5] && (m_rt[k] != 5'd0) &&
           ((m_rt[k] == id_if.rs) || (m_rt[k] == id_if.rt));
      stalling = !flush && ((m_hold[k] > 0) || hz);
`ifdef HAZARD_PERF_EN
      exp_sc = m_sc[k];
      exp_fc = m_fc[k];
`else
      exp_sc = 32'd0;
      exp_fc = 32'd0;
`endif
      if (m_known) begin
        chk($sformatf("s%0d.ex_valid", stall_len[k]), {31'd0, o_valid[k]}, {31'd0, m_valid[k]});
        chk($sformatf("s%0d.ex_ctrl", stall_len[k]), {23'd0, o_ctrl[k]}, {23'd0, m_ctrl[k]});
        chk($sformatf("s%0d.pc_write", stall_len[k]), {31'd0, o_pcw[k]}, {31'd0, !stalling});
        chk($sformatf("s%0d.ifid_write", stall_len[k]), {31'd0, o_ifw[k]}, {31'd0, !stalling});
        chk($sformatf("s%0d.stall_cnt", stall_len[k]), o_sc[k], exp_sc);
        chk($sformatf("s%0d.flush_cnt", stall_len[k]), o_fc[k], exp_fc);
        if (m_valid[k]) begin
          chk($sformatf("s%0d.ex_pc4", stall_len[k]), o_pc4[k], m_pc4[k]);
          chk($sformatf("s%0d.ex_rs_data", stall_len[k]), o_rsd[k], m_rsd[k]);
          chk($sformatf("s%0d.ex_rt_data", stall_len[k]), o_rtd[k], m_rtd[k]);
          chk($sformatf("s%0d.ex_imm", stall_len[k]), o_imm[k], m_imm[k]);
          chk($sformatf("s%0d.ex_rs", stall_len[k]), {27'd0, o_rs[k]}, {27'd0, m_rs[k]});
          chk($sformatf("s%0d.ex_rt", stall_len[k]), {27'd0, o_rt[k]}, {27'd0, m_rt[k]});
          chk($sformatf("s%0d.ex_rd", stall_len[k]), {27'd0, o_rd[k]}, {27'd0, m_rd[k]});
        end
      end
      // Advance the model to what the coming clock edge must produce.
      if (!rst_n) begin
        m_valid[k] = 1'b0; m_ctrl[k] = 9'h0; m_rt[k] = 5'd0;
        m_hold[k] = 0; m_sc[k] = 32'd0; m_fc[k] = 32'd0;
      end else begin
        if (stalling) m_sc[k] = m_sc[k] + 32'd1;
        if (flush && id_if.valid) m_fc[k] = m_fc[k] + 32'd1;
        if (flush) begin
          m_valid[k] = 1'b0; m_ctrl[k] = 9'h0; m_hold[k] = 0;
        end else if (m_hold[k] > 0) begin
          m_valid[k] = 1'b0; m_ctrl[k] = 9'h0; m_hold[k] = m_hold[k] - 1;
        end else if (hz) begin
          m_valid[k] = 1'b0; m_ctrl[k] = 9'h0; m_hold[k] = stall_len[k] - 1;
        end else begin
          m_valid[k] = id_if.valid;
          m_ctrl[k]  = id_if.valid ? id_if.ctrl : 9'h0;
          m_pc4[k] = id_if.pc4; m_rsd[k] = id_if.rs_data; m_rtd[k] = id_if.rt_data;
          m_imm[k] = id_if.imm; m_rs[k] = id_if.rs; m_rt[k] = id_if.rt; m_rd[k] = id_if.rd;
        end
      end
    end
    if (!rst_n) m_known = 1'b1;
  end

  task automatic drive(input logic v, input logic [8:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic fl);
    @(posedge clk);
    #1;
    id_if.valid   = v;
    id_if.ctrl    = c;
    id_if.rs      = rs;
    id_if.rt      = rt;
    id_if.rd      = rd;
    id_if.rs_data = rsd;
    id_if.rt_data = rtd;
    id_if.imm     = {16'hFFFF, rtd[15:0]} ^ 32'h0F0F_0000;
    id_if.pc4     = id_if.pc4 + 32'd4;
    flush         = fl;
  endtask

  task automatic idle();
    drive(1'b0, 9'h000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  int n_hold [2];
  int n_bub  [2];

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    id_if.valid = 1'b1; id_if.ctrl = 9'h1A4; id_if.pc4 = 32'h0000_1000;
    id_if.rs = 5'd8; id_if.rt = 5'd8; id_if.rd = 5'd0;
    id_if.rs_data = 32'd1; id_if.rt_data = 32'd2; id_if.imm = 32'd3;

    // Reset held for two clocks with a load word on the ID bus.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ex_ctrl_s1", {23'd0, ex1.ctrl}, 32'h0);
    chk("rst.ex_ctrl_s3", {23'd0, ex3.ctrl}, 32'h0);
    chk("rst.ex_rd_s1", {27'd0, ex1.rd}, 32'h0);
    chk("rst.pc_write_s3", {31'd0, pcw3}, 32'h1);
    chk("rst.ifid_write_s1", {31'd0, ifw1}, 32'h1);
    rst_n = 1'b1; id_if.valid = 1'b0;

    // R-type pass-through.
    drive(1'b1, 9'h08A, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0);
    idle();
    @(negedge clk);
    chk("pass.ex_ctrl_s1", {23'd0, ex1.ctrl}, 32'h08A);
    chk("pass.ex_rd_s3", {27'd0, ex3.rd}, 32'd3);
    chk("pass.ex_rs_data_s1", ex1.rs_data, 32'd5);
    chk("pass.ex_valid_s3", {31'd0, ex3.valid}, 32'h1);

    // Invalid slot carrying a load control word becomes a bubble.
    drive(1'b0, 9'h1A4, 5'd8, 5'd8, 5'd0, 32'd9, 32'd9, 1'b0);
    idle();
    @(negedge clk);
    chk("inv.ex_ctrl_s1", {23'd0, ex1.ctrl}, 32'h0);

    // Load-use: lw rt=8 followed by a reader of $8, held steady through the stall.
    drive(1'b1, 9'h1A4, 5'd9, 5'd8, 5'd0, 32'd100, 32'd200, 1'b0);
    drive(1'b1, 9'h08A, 5'd8, 5'd4, 5'd5, 32'd11, 32'd22, 1'b0);
    n_hold = '{0, 0};
    n_bub  = '{0, 0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!o_pcw[k]) n_hold[k]++;
        if (c > 0 && !o_valid[k]) n_bub[k]++;
      end
    end
    chk("lu.holds_s1", n_hold[0], 32'd1);
    chk("lu.holds_s3", n_hold[1], 32'd3);
    chk("lu.bubbles_s1", n_bub[0], 32'd1);
    chk("lu.bubbles_s3", n_bub[1], 32'd3);
    chk("lu.ex_ctrl_s3", {23'd0, ex3.ctrl}, 32'h08A);
    chk("lu.ex_rd_s1", {27'd0, ex1.rd}, 32'd5);
`ifdef HAZARD_PERF_EN
    chk("lu.stall_cnt_s1", sc1, 32'd1);
    chk("lu.stall_cnt_s3", sc3, 32'd3);
`endif

    // Load to $0 and a non-load producer never stall.
    drive(1'b1, 9'h1A4, 5'd3, 5'd0, 5'd0, 32'd1, 32'd2, 1'b0);
    drive(1'b1, 9'h08A, 5'd0, 5'd0, 5'd6, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    chk("r0.pc_write_s3", {31'd0, pcw3}, 32'h1);
    drive(1'b1, 9'h08A, 5'd1, 5'd8, 5'd8, 32'd5, 32'd6, 1'b0);
    drive(1'b1, 9'h08A, 5'd8, 5'd2, 5'd9, 32'd7, 32'd8, 1'b0);
    @(negedge clk);
    chk("nonload.pc_write_s3", {31'd0, pcw3}, 32'h1);

    // Flush in the second stall cycle.
    idle();
    drive(1'b1, 9'h1A4, 5'd9, 5'd8, 5'd0, 32'd100, 32'd200, 1'b0);
    drive(1'b1, 9'h08A, 5'd8, 5'd4, 5'd5, 32'd11, 32'd22, 1'b0);
    @(negedge clk);
    chk("fl.first_hold_s3", {31'd0, pcw3}, 32'h0);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("fl.pc_write_s3", {31'd0, pcw3}, 32'h1);
    @(posedge clk); #1 flush = 1'b0; id_if.valid = 1'b0;
    @(negedge clk);
    chk("fl.ex_valid_s3", {31'd0, ex3.valid}, 32'h0);
    chk("fl.resume_s3", {31'd0, pcw3}, 32'h1);
`ifdef HAZARD_PERF_EN
    chk("fl.flush_cnt_s3", fc3, 32'd1);
`endif

    // Hazard and flush together: flush wins, nothing held.
    drive(1'b1, 9'h1A4, 5'd9, 5'd8, 5'd0, 32'd1, 32'd2, 1'b0);
    drive(1'b1, 9'h08A, 5'd8, 5'd4, 5'd5, 32'd3, 32'd4, 1'b1);
    @(negedge clk);
    chk("hzfl.pc_write_s1", {31'd0, pcw1}, 32'h1);
    chk("hzfl.pc_write_s3", {31'd0, pcw3}, 32'h1);
    idle();

    // Reset in the middle of a stall.
    drive(1'b1, 9'h1A4, 5'd9, 5'd8, 5'd0, 32'd1, 32'd2, 1'b0);
    drive(1'b1, 9'h08A, 5'd8, 5'd4, 5'd5, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid.still_held_s3", {31'd0, pcw3}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; id_if.valid = 1'b0;
    @(negedge clk);
    chk("rstmid.pc_write_s3", {31'd0, pcw3}, 32'h1);
    chk("rstmid.stall_cnt_s3", sc3, 32'd0);

    repeat (3) idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
